bn_lane_pipe: RTL and testbench
===============================

# bn_lane_pipe

Parametrised batch-normalisation stage for the PPG-to-CO inference datapath. It normalises one frame of CH fixed-point activations per transaction: out = sat(round(((x − mean)·scale) >>> FRAC) + beta), with optional ReLU. The block replaces fixed, hard-coded coefficient BN layers and sits between a conv/dense layer output and the next layer input. It adds runtime-loadable coefficients, LANES-way time-multiplexed arithmetic, rounding, saturation, and a full valid/ready handshake on both sides.

## Interface
Parameters:
- CH, 32, channels per frame; must be a multiple of LANES.
- LANES, 4, channels processed per cycle; G = CH/LANES groups.
- DW, 16, data/coefficient width (signed).
- FRAC, 12, fractional bits of data and scale (Q4.12 at default).
- RELU_EN, 0, when 1, a runtime `relu` input is honoured; when 0, ReLU is never applied.

Ports:
- clk, in, 1, single clock; all logic is on its rising edge.
- reset, in, 1, synchronous, active-low reset (asserted when 0).
- in_valid, in, 1, input frame valid.
- in_ready, out, 1, block can accept a frame.
- in_data, in, CH×DW, signed input frame, unpacked array [0:CH-1].
- out_valid, out, 1, output frame valid.
- out_ready, in, 1, downstream accepts frame.
- out_data, out, CH×DW, signed result frame [0:CH-1].
- relu, in, 1, applies ReLU to the frame; sampled at input acceptance.
- cfg_we, in, 1, coefficient write strobe.
- cfg_sel, in, 2, 0 = mean, 1 = scale (gamma/√(var+ε), Q4.12), 2 = beta, 3 = reserved (write ignored).
- cfg_addr, in, clog2(CH), channel index.
- cfg_data, in, DW, coefficient value.
- cfg_ready, out, 1, high only in IDLE; writes with cfg_ready = 0 are dropped.

## Operation
- FSM states: IDLE → RUN → DRAIN → HOLD → IDLE.
- IDLE: in_ready = 1 and cfg_ready = 1. An in_valid handshake captures in_data and relu into the frame buffer, sets g = 0, and moves the FSM to RUN.
- RUN: issues group g (channels g·LANES…g·LANES+LANES−1) into the lane pipes each cycle. After g = G−1, the FSM moves to DRAIN.
- DRAIN: 2 cycles while the pipe empties, then HOLD.
- HOLD: out_valid = 1 and out_data is stable. On out_ready = 1, the FSM moves to IDLE. in_ready stays 0 in HOLD, even while out_ready is high.
- Per-lane arithmetic:
  - d = x − mean, DW+1 bits.
  - p = d·scale, 2DW+1 bits, registered (stage 1).
  - r = (p + 2^(FRAC−1)) >>> FRAC, which is round-half-up.
  - s = r + beta.
  - Saturate s to [−2^(DW−1), 2^(DW−1)−1].
  - If relu is applied and the result is < 0, the result is 0.
  - Result is registered into out_data[ch] (stage 2).
- Coefficient writes take effect on the next cycle. A write in the same cycle as an input acceptance is applied; the accepted frame uses the new value.
- Reset:
  - FSM goes to IDLE; out_valid = 0; out_data all 0; in_ready = 1 from the first cycle after reset is released.
  - Coefficients reset to mean = 0, scale = 2^FRAC, beta = 0.
  - Reset mid-RUN/HOLD aborts the frame with no output.

## Timing
- Input accepted at cycle 0 (in_valid & in_ready).
- RUN occupies cycles 1…G; DRAIN occupies cycles G+1…G+2.
- out_valid first rises at cycle G+3 (cycle 11 at defaults).
- Minimum frame period with out_ready held high is G+4 cycles.
- out_data changes only on reset or in the RUN/DRAIN cycles that write it. It is never modified while out_valid = 1.
- in_valid while in_ready = 0 has no effect; upstream must hold data.

## Structure
- Package bn_pkg holds:
  - typedef for the signed DW word and the CH-frame array;
  - cfg_sel encodings;
  - default-coefficient constants;
  - the sat function.
- Sub-module bn_lane: one two-stage arithmetic lane (d, p, round, beta, sat, ReLU) with a pipeline valid and channel-index tag. It is instantiated LANES times.
- The top level holds the FSM, the group counter, the coefficient register files, and the output buffer write-back.

## Test plan
- After reset, send x[all] = 4096 with default coefficients → out_valid at cycle 11, every out = 4096; next frame accepted only after out_ready.
- Load mean[3] = 1000, scale[3] = 8192, beta[3] = −50, then send x[3] = 3048 → out[3] = 4046; other channels pass through unchanged.
- Rounding: scale = 2048, x = 1 → 1; x = −1 → 0; x = 3 → 2.
- Saturation: mean[0] = −32768, scale[0] = 8192, x[0] = 32767 → 32767; x[1] = −32768 with mean[1] = 32767 → −32768.
- ReLU (RELU_EN = 1): relu = 1, x = −4096 → 0; relu = 0 → −4096. Hold out_ready = 0 for 20 cycles → out_data stable, in_ready = 0, cfg write dropped.
- Drop reset low in RUN at cycle 4 → next cycle out_valid = 0, out_data = 0, state IDLE; a new frame then completes normally.

Source files
------------

// File: rtl/bn_pkg.sv
// bn_pkg: shared types, cfg encodings, default coefficients and saturation helper for bn_lane_pipe
package bn_pkg;
  localparam int CH_D = 32;
  localparam int DW_D = 16;
  localparam int FRAC_D = 12;
  localparam int DEF_MEAN = 0;
  localparam int DEF_BETA = 0;
  typedef logic signed [DW_D-1:0] word_t;
  typedef word_t frame_t [0:CH_D-1];
  typedef enum logic [1:0] {SEL_MEAN, SEL_SCALE, SEL_BETA, SEL_RSVD} sel_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  function automatic logic signed [63:0] def_scale(input int frac);
    return 64'sd1 <<< frac;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] s, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/bn_lane.sv
// bn_lane: two-stage BN lane, product registered first, then rounded/biased/saturated result
module bn_lane
  import bn_pkg::*;
#(
  parameter int DW = 16,
  parameter int FRAC = 12,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v,
  input  logic [AW-1:0]        tag,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] mean,
  input  logic signed [DW-1:0] scale,
  input  logic signed [DW-1:0] beta,
  input  logic                 relu,
  output logic                 ov,
  output logic [AW-1:0]        otag,
  output logic signed [DW-1:0] y
);
  localparam int PW = 2 * DW + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
  logic signed [DW:0] d;
  logic signed [PW-1:0] p, p1, r, s;
  logic signed [DW-1:0] beta1, sat_s;
  logic v1, relu1;
  logic [AW-1:0] tag1;
  assign d = {x[DW-1], x} - {mean[DW-1], mean};
  assign p = PW'(d) * PW'(scale);
  assign r = (p1 + HALF) >>> FRAC;
  assign s = r + PW'(beta1);
  assign sat_s = DW'(sat(64'(s), DW));
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
      ov <= 1'b0;
      tag1 <= '0;
      otag <= '0;
      p1 <= '0;
      beta1 <= '0;
      relu1 <= 1'b0;
      y <= '0;
    end else begin
      v1 <= v;
      tag1 <= tag;
      p1 <= p;
      beta1 <= beta;
      relu1 <= relu;
      ov <= v1;
      otag <= tag1;
      y <= (relu1 && sat_s < 0) ? '0 : sat_s;
    end
  end
endmodule

// File: rtl/bn_lane_pipe.sv
// bn_lane_pipe: frame-level batch-norm stage, LANES channels per cycle, valid/ready on both sides
module bn_lane_pipe
  import bn_pkg::*;
#(
  parameter int CH = 32,
  parameter int LANES = 4,
  parameter int DW = 16,
  parameter int FRAC = 12,
  parameter int RELU_EN = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_data [0:CH-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    out_data [0:CH-1],
  input  logic                    relu,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [$clog2(CH)-1:0]   cfg_addr,
  input  logic signed [DW-1:0]    cfg_data,
  output logic                    cfg_ready
);
  localparam int G = CH / LANES;
  localparam int AW = $clog2(CH);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  state_t state;
  logic [GW-1:0] g;
  logic dcnt, relu_q;
  logic signed [DW-1:0] buf_x [0:CH-1];
  logic signed [DW-1:0] mean [0:CH-1];
  logic signed [DW-1:0] scale [0:CH-1];
  logic signed [DW-1:0] beta [0:CH-1];
  logic [LANES-1:0] lv;
  logic [AW-1:0] lt [0:LANES-1];
  logic signed [DW-1:0] ly [0:LANES-1];
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx = AW'(int'(g) * LANES + k);
    bn_lane #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_lane (
      .clk(clk), .reset(reset), .v(state == RUN), .tag(idx),
      .x(buf_x[idx]), .mean(mean[idx]), .scale(scale[idx]), .beta(beta[idx]),
      .relu(RELU_EN != 0 && relu_q), .ov(lv[k]), .otag(lt[k]), .y(ly[k])
    );
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      g <= '0;
      dcnt <= 1'b0;
      relu_q <= 1'b0;
      in_ready <= 1'b1;
      cfg_ready <= 1'b1;
      out_valid <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        mean[i] <= DW'(DEF_MEAN);
        scale[i] <= DW'(def_scale(FRAC));
        beta[i] <= DW'(DEF_BETA);
        out_data[i] <= '0;
      end
    end else begin
      if (cfg_we && cfg_ready) begin
        if (cfg_sel == SEL_MEAN) mean[cfg_addr] <= cfg_data;
        if (cfg_sel == SEL_SCALE) scale[cfg_addr] <= cfg_data;
        if (cfg_sel == SEL_BETA) beta[cfg_addr] <= cfg_data;
      end
      for (int k = 0; k < LANES; k++)
        if (lv[k]) out_data[lt[k]] <= ly[k];
      case (state)
        IDLE: if (in_valid) begin
          buf_x <= in_data;
          relu_q <= relu;
          g <= '0;
          in_ready <= 1'b0;
          cfg_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          g <= g + 1'b1;
          dcnt <= 1'b0;
          if (g == GW'(G - 1)) state <= DRAIN;
        end
        DRAIN: begin
          dcnt <= 1'b1;
          if (dcnt) begin
            out_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          cfg_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bn_lane_pipe.sv
// tb_bn_lane_pipe: directed checks of latency, arithmetic, rounding, saturation, ReLU, hold and reset abort
module tb_bn_lane_pipe;
  import bn_pkg::*;
  logic clk, reset, in_valid, in_ready, out_valid, out_ready, relu, cfg_we, cfg_ready;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_addr;
  logic signed [15:0] cfg_data;
  frame_t in_data, out_data, xv;
  int n_cmp = 0, n_bad = 0;

  bn_lane_pipe #(.CH(32), .LANES(4), .DW(16), .FRAC(12), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .relu(relu),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer got, input integer exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input int addr, input int data);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = 5'(addr);
    cfg_data = 16'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic r);
    int n;
    in_data = xv;
    relu = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, 10);
    chk("hold_in_ready", in_ready, 0);
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    relu = 1'b0;
    cfg_we = 1'b0;
    cfg_sel = 2'd0;
    cfg_addr = '0;
    cfg_data = '0;
    for (int i = 0; i < 32; i++) xv[i] = 16'sd4096;
    in_data = xv;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_out0", out_data[0], 0);
    chk("rst_out31", out_data[31], 0);

    send(1'b0);
    for (int i = 0; i < 32; i++) chk($sformatf("pass[%0d]", i), out_data[i], 4096);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("hold_valid", out_valid, 1);
    chk("hold_ready_busy", in_ready, 0);
    release_frame();

    cfg(SEL_MEAN, 3, 1000);
    cfg(SEL_SCALE, 3, 8192);
    cfg(SEL_BETA, 3, -50);
    cfg(SEL_SCALE, 8, 2048);
    cfg(SEL_SCALE, 9, 2048);
    cfg(SEL_SCALE, 10, 2048);
    cfg(SEL_MEAN, 0, -32768);
    cfg(SEL_SCALE, 0, 8192);
    cfg(SEL_MEAN, 1, 32767);
    cfg(SEL_RSVD, 5, 999);
    xv[3] = 16'sd3048;
    xv[8] = 16'sd1;
    xv[9] = -16'sd1;
    xv[10] = 16'sd3;
    xv[0] = 16'sd32767;
    xv[1] = -16'sd32768;
    xv[20] = 16'sd0;
    cfg_we = 1'b1;
    cfg_sel = SEL_BETA;
    cfg_addr = 5'd20;
    cfg_data = 16'sd7;
    send(1'b0);
    chk("coef_ch3", out_data[3], 4046);
    chk("round_p1", out_data[8], 1);
    chk("round_m1", out_data[9], 0);
    chk("round_p3", out_data[10], 2);
    chk("sat_hi", out_data[0], 32767);
    chk("sat_lo", out_data[1], -32768);
    chk("cfg_same_cycle", out_data[20], 7);
    chk("rsvd_ignored", out_data[5], 4096);
    chk("other_ch2", out_data[2], 4096);
    chk("other_ch31", out_data[31], 4096);
    release_frame();

    xv[12] = -16'sd4096;
    send(1'b1);
    chk("relu_neg", out_data[12], 0);
    chk("relu_pos", out_data[2], 4096);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        cfg_we = 1'b1;
        cfg_sel = SEL_MEAN;
        cfg_addr = 5'd12;
        cfg_data = 16'sd100;
      end
      if (i == 6) cfg_we = 1'b0;
      tick();
    end
    chk("stall_out12", out_data[12], 0);
    chk("stall_out2", out_data[2], 4096);
    chk("stall_valid", out_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_cfg_ready", cfg_ready, 0);
    release_frame();
    send(1'b0);
    chk("norelu_neg", out_data[12], -4096);
    release_frame();

    in_data = xv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out12", out_data[12], 0);
    chk("abort_out2", out_data[2], 0);
    chk("abort_in_ready", in_ready, 1);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) xv[i] = 16'sd100;
    repeat (12) tick();
    chk("abort_no_output", out_valid, 0);
    send(1'b0);
    chk("post_rst_ch3", out_data[3], 100);
    chk("post_rst_ch0", out_data[0], 100);
    chk("post_rst_ch31", out_data[31], 100);
    release_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
